age_ordered_rs: RTL
===================

// Module: age_ordered_rs
// PURPOSE
//  Parametrised reservation station, successor of the fixed 8-entry ALU RS. Holds up to DEPTH dispatched ops.
//  Captures operand values from NCDB common-data-bus ports and issues the OLDEST ready entry to one
//  functional unit over a valid/ready handshake.
//  Sits between ROB/regfile dispatch and one FU (ALU, CMP, ...). One instance per FU class.
// PARAMETERS
//  DEPTH  8   entries (>=2)
//  XLEN   32  operand/data width
//  TAGW   4   ROB tag width; tag travels in src[TAGW-1:0] while busy
//  OPW    7   opcode/control field width
//  NCDB   2   number of CDB write-back ports
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  synchronous active-high reset
//  flush        in   1                  squash all entries (branch mispredict)
//  disp_valid   in   1                  dispatch request
//  disp_ready   out  1                  entry free (registered state only, no path from iss_ready)
//  disp_op      in   OPW                opcode/control
//  disp_tag     in   TAGW               destination ROB tag
//  disp_busy1   in   1                  src1 is a tag (1) or a value (0); same meaning for disp_busy2
//  disp_src1    in   XLEN               src1 value or tag; same for disp_src2
//  disp_busy2   in   1
//  disp_src2    in   XLEN
//  cdb_valid    in   NCDB               per-port write-back strobe
//  cdb_tag      in   NCDB x TAGW        write-back ROB tag
//  cdb_data     in   NCDB x XLEN        write-back value
//  iss_valid    out  1                  an entry is ready to issue
//  iss_ready    in   1                  FU accepts
//  iss_op       out  OPW                issued op, with iss_a, iss_b, iss_tag
//  iss_a        out  XLEN
//  iss_b        out  XLEN
//  iss_tag      out  TAGW
//  num_free     out  $clog2(DEPTH+1)    free entries (registered count)
// BEHAVIOUR
//  - Reset (rst) or flush: all entries invalid, age matrix cleared, num_free=DEPTH, disp_ready=1 next
//    cycle. iss_valid forced 0 in the flush/rst cycle. A dispatch in that cycle is dropped.
//  - Entry: valid, op, tag, busy1/2, src1/2. An entry is ready when valid && !busy1 && !busy2.
//  - Dispatch (disp_valid && disp_ready) writes the lowest-index free entry. Its age row is set older-than=0.
//    Every other valid entry is marked older than it.
//  - Dispatch bypass: if disp_busyN and a CDB port matches disp_srcN[TAGW-1:0] in the same cycle, the
//    entry stores cdb_data with busyN=0.
//  - Wakeup: each cycle, for each valid entry with busyN=1, the lowest-index CDB port k satisfying
//    cdb_valid[k] && cdb_tag[k]==srcN[TAGW-1:0] writes srcN<=cdb_data[k] and busyN<=0.
//    Ports 1..NCDB-1 with the same match are ignored.
//  - Wakeup-to-issue: an entry woken in cycle t is eligible in cycle t+1; no same-cycle CDB->issue forwarding.
//  - Select (combinational from registered state): the oldest ready entry drives iss_*. iss_valid=1 if one exists.
//    When iss_valid=0, iss_* are don't-care, held at 0.
//  - Issue fires on iss_valid && iss_ready. The entry is freed at the next edge, and its age-matrix row and
//    column are cleared.
//  - If iss_ready=0, the selection may change next cycle only if an older entry becomes ready.
//    The FU must not depend on iss_* being stable.
//  - Full: disp_ready=0 when num_free==0, even if an issue fires the same cycle (1-cycle bubble accepted).
//  - Same-cycle dispatch and issue: both take effect, num_free unchanged.
//    The freed entry is not reused in that cycle.
//  - num_free = DEPTH - popcount(valid), registered; never under- or overflows.
//  - Latency: dispatch with both operands ready -> iss_valid next cycle.
// STRUCTURE
//  - Shared types package: rs_entry_t {valid, op, tag, busy1, busy2, src1, src2}, parametrised via package
//    localparams XLEN/TAGW/OPW, and cdb_t {valid, tag, data}.
//  - Sub-module rs_age_select: inputs ready[DEPTH] and age matrix, outputs one-hot grant + found.
//    Purely combinational; the parent holds all state.
// TESTING
//  1. Reset then dispatch op=0x33 tag=3 src1=5 src2=7 (busy=0), iss_ready=1 -> next cycle iss_valid=1,
//     iss_a=5, iss_b=7, iss_tag=3; the cycle after, num_free=8.
//  2. Dispatch tag=1 busy1 src1=tag 9; then drive CDB0 tag 9 data 0xDEAD -> iss_valid one cycle after the CDB,
//     iss_a=0xDEAD.
//  3. Dispatch tags 1,2,3 all ready with iss_ready=0, then set iss_ready=1 -> issue order 1,2,3 regardless of
//     entry index. Repeat after freeing entry 0 so tag 4 lands in slot 0; tag 4 issues last.
//  4. Fill 8 entries, all waiting on tag 5 -> disp_ready=0, num_free=0. CDB tag 5 -> all wake, 8 issues in age order,
//     then disp_ready=1, num_free=8.
//  5. CDB0 and CDB1 both carry tag 6 with data 0x11/0x22 -> waiting entry captures 0x11.
//     Dispatch of busy tag 6 during the same cycle captures 0x11 with busy=0.
//  6. With 4 valid entries, assert flush together with disp_valid -> next cycle num_free=8, iss_valid=0,
//     the dispatched op is absent. rst mid-wakeup behaves the same.

Source files
------------

// File: rtl/age_ordered_rs_pkg.sv
// Shared types for the age-ordered reservation station.
// Entry and CDB bundles are sized by the widths below.
package age_ordered_rs_pkg;

   localparam int XLEN = 32;
   localparam int TAGW = 4;
   localparam int OPW  = 7;

   typedef struct packed {
      logic            valid;
      logic [OPW-1:0]  op;
      logic [TAGW-1:0] tag;
      logic            busy1;
      logic            busy2;
      logic [XLEN-1:0] src1;
      logic [XLEN-1:0] src2;
   } rs_entry_t;

   typedef struct packed {
      logic            valid;
      logic [TAGW-1:0] tag;
      logic [XLEN-1:0] data;
   } cdb_t;

   function automatic logic tag_hit(cdb_t c, logic [TAGW-1:0] t);
      return c.valid && (c.tag == t);
   endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker over an age matrix.
// i_age[j][i] set means entry j is older than entry i.
module rs_age_select #(
   parameter int DEPTH = 8
) (
   input  logic [DEPTH-1:0]            i_ready,
   input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
   output logic [DEPTH-1:0]            o_grant,
   output logic                        o_found
);

   always_comb begin
      o_grant = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_grant[i] = i_ready[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (i_ready[j] && i_age[j][i]) o_grant[i] = 1'b0;
         end
      end
   end

   assign o_found = |i_ready;

endmodule

// File: rtl/age_ordered_rs.sv
// Reservation station: CDB wakeup, dispatch bypass and
// oldest-ready issue to one functional unit.
module age_ordered_rs
   import age_ordered_rs_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int NCDB  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic [OPW-1:0]             disp_op,
   input  logic [TAGW-1:0]            disp_tag,
   input  logic                       disp_busy1,
   input  logic [XLEN-1:0]            disp_src1,
   input  logic                       disp_busy2,
   input  logic [XLEN-1:0]            disp_src2,
   input  logic [NCDB-1:0]            cdb_valid,
   input  logic [NCDB-1:0][TAGW-1:0]  cdb_tag,
   input  logic [NCDB-1:0][XLEN-1:0]  cdb_data,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output logic [OPW-1:0]             iss_op,
   output logic [XLEN-1:0]            iss_a,
   output logic [XLEN-1:0]            iss_b,
   output logic [TAGW-1:0]            iss_tag,
   output logic [$clog2(DEPTH+1)-1:0] num_free
);

   localparam int CW = $clog2(DEPTH+1);

   rs_entry_t                   r_ent [DEPTH];
   logic [DEPTH-1:0][DEPTH-1:0] r_age;
   logic [CW-1:0]               r_num_free;

   rs_entry_t                   w_nxt [DEPTH];
   logic [DEPTH-1:0][DEPTH-1:0] w_nxt_age;
   cdb_t                        w_cdb [NCDB];
   rs_entry_t                   w_new;
   logic [DEPTH-1:0]            w_valid;
   logic [DEPTH-1:0]            w_ready;
   logic [DEPTH-1:0]            w_free_oh;
   logic [DEPTH-1:0]            w_grant;
   logic                        w_found;
   logic                        w_kill;
   logic                        w_disp_fire;
   logic                        w_iss_fire;

   always_comb begin
      for (int k = 0; k < NCDB; k++) begin
         w_cdb[k] = '{valid: cdb_valid[k], tag: cdb_tag[k],
                      data: cdb_data[k]};
      end
   end

   always_comb begin
      w_valid = '0;
      w_ready = '0;
      for (int e = 0; e < DEPTH; e++) begin
         w_valid[e] = r_ent[e].valid;
         w_ready[e] = r_ent[e].valid & ~r_ent[e].busy1
                      & ~r_ent[e].busy2;
      end
   end

   // lowest free slot: isolate the lowest zero of the valid vector
   assign w_free_oh   = ~w_valid & (w_valid + DEPTH'(1));
   assign w_kill      = rst | flush;
   assign disp_ready  = (r_num_free != '0);
   assign w_disp_fire = disp_valid & disp_ready & ~w_kill;
   assign iss_valid   = w_found & ~w_kill;
   assign w_iss_fire  = iss_valid & iss_ready;
   assign num_free    = r_num_free;

   rs_age_select #(.DEPTH(DEPTH)) u_sel (
      .i_ready (w_ready),
      .i_age   (r_age),
      .o_grant (w_grant),
      .o_found (w_found)
   );

   // descending port scan so the lowest matching port wins
   always_comb begin
      w_new = '{valid: 1'b1, op: disp_op, tag: disp_tag,
                busy1: disp_busy1, busy2: disp_busy2,
                src1: disp_src1, src2: disp_src2};
      for (int k = NCDB-1; k >= 0; k--) begin
         if (disp_busy1 && tag_hit(w_cdb[k], disp_src1[TAGW-1:0])) begin
            w_new.busy1 = 1'b0;
            w_new.src1  = w_cdb[k].data;
         end
         if (disp_busy2 && tag_hit(w_cdb[k], disp_src2[TAGW-1:0])) begin
            w_new.busy2 = 1'b0;
            w_new.src2  = w_cdb[k].data;
         end
      end
   end

   always_comb begin
      w_nxt     = r_ent;
      w_nxt_age = r_age;
      for (int e = 0; e < DEPTH; e++) begin
         for (int k = NCDB-1; k >= 0; k--) begin
            if (r_ent[e].valid && r_ent[e].busy1 &&
                tag_hit(w_cdb[k], r_ent[e].src1[TAGW-1:0])) begin
               w_nxt[e].busy1 = 1'b0;
               w_nxt[e].src1  = w_cdb[k].data;
            end
            if (r_ent[e].valid && r_ent[e].busy2 &&
                tag_hit(w_cdb[k], r_ent[e].src2[TAGW-1:0])) begin
               w_nxt[e].busy2 = 1'b0;
               w_nxt[e].src2  = w_cdb[k].data;
            end
         end
         if (w_disp_fire && w_free_oh[e]) begin
            w_nxt[e]     = w_new;
            w_nxt_age[e] = '0;
         end
         for (int j = 0; j < DEPTH; j++) begin
            if (w_disp_fire && w_free_oh[j]) w_nxt_age[e][j] = w_valid[e];
         end
      end
      for (int e = 0; e < DEPTH; e++) begin
         if (w_iss_fire && w_grant[e]) begin
            w_nxt[e].valid = 1'b0;
            w_nxt_age[e]   = '0;
            for (int j = 0; j < DEPTH; j++) w_nxt_age[j][e] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_kill) begin
         for (int e = 0; e < DEPTH; e++) r_ent[e] <= '0;
         r_age      <= '0;
         r_num_free <= CW'(DEPTH);
      end else begin
         r_ent      <= w_nxt;
         r_age      <= w_nxt_age;
         r_num_free <= r_num_free + CW'(w_iss_fire) - CW'(w_disp_fire);
      end
   end

   always_comb begin
      iss_op  = '0;
      iss_a   = '0;
      iss_b   = '0;
      iss_tag = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (iss_valid && w_grant[e]) begin
            iss_op  = r_ent[e].op;
            iss_a   = r_ent[e].src1;
            iss_b   = r_ent[e].src2;
            iss_tag = r_ent[e].tag;
         end
      end
   end

endmodule
